// File: rtl/mem_responder.sv
// mem_responder
//   Memory-side responder for the multi-cycle RV32i core's unified
//   instruction/data port. It accepts one read or write request at a time
//   from IDLE, holds it for WAIT_CYCLES wait states, and then completes it
//   with a one-cycle mem_ready pulse. Illegal requests are flagged with err
//   and never touch the array.
//
//   Optional build macro: MEM_ACCESS_CNT_EN adds the rd_count/wr_count
//   ports, which count successfully completed reads and writes.
//
//   Ports:
//     clk        rising-edge clock
//     rst        asynchronous, active-low reset
//     mem_read   read request strobe (sampled only in IDLE)
//     mem_write  write request strobe (sampled only in IDLE)
//     addr       byte address, must be word aligned
//     wdata      write data
//     byte_en    write lane enables, bit i selects wdata[8i+7:8i]
//     rdata      read data, held until the next read completes
//     mem_ready  one-cycle completion pulse
//     busy       high from acceptance through the mem_ready cycle
//     err        high with mem_ready when the request was illegal
//     rd_count   (MEM_ACCESS_CNT_EN only) successful reads, wrapping
//     wr_count   (MEM_ACCESS_CNT_EN only) successful writes, wrapping

module mem_responder #(
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [31:0] ERR_DATA    = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  byte_en,
    output logic [31:0] rdata,
    output logic        mem_ready,
    output logic        busy,
    output logic        err
`ifdef MEM_ACCESS_CNT_EN
    ,
    output logic [31:0] rd_count,
    output logic [31:0] wr_count
`endif
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    logic [31:0] mem [DEPTH];

    state_t        state_q,    state_d;
    logic [CW-1:0] cnt_q,      cnt_d;
    logic [AW-1:0] widx_q,     widx_d;
    logic [31:0]   wdata_q,    wdata_d;
    logic [3:0]    be_q,       be_d;
    logic          is_read_q,  is_read_d;
    logic          err_req_q,  err_req_d;
    logic          wr_pend_q,  wr_pend_d;
    logic [31:0]   rdata_q,    rdata_d;
    logic          ready_q,    ready_d;
    logic          busy_q,     busy_d;
    logic          err_q,      err_d;
`ifdef MEM_ACCESS_CNT_EN
    logic [31:0]   rd_cnt_q,   rd_cnt_d;
    logic [31:0]   wr_cnt_q,   wr_cnt_d;
`endif

    // Next-state logic. The state register tracks the request; all outputs
    // are computed here and registered, so the mem_ready pulse appears in the
    // cycle after the FSM sits in RESP. The legality check is folded into a
    // single latched flag at acceptance so later stages only consult err_req_q.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        widx_d    = widx_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        is_read_d = is_read_q;
        err_req_d = err_req_q;
        wr_pend_d = 1'b0;
        rdata_d   = rdata_q;
        ready_d   = 1'b0;
        busy_d    = 1'b0;
        err_d     = 1'b0;
`ifdef MEM_ACCESS_CNT_EN
        rd_cnt_d  = rd_cnt_q;
        wr_cnt_d  = wr_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (mem_read || mem_write) begin
                    widx_d    = addr[AW+1:2];
                    wdata_d   = wdata;
                    be_d      = byte_en;
                    is_read_d = mem_read;
                    err_req_d = (addr[1:0] != 2'b00)
                              || ({2'b00, addr[31:2]} >= DEPTH)
                              || (mem_read && mem_write);
                    busy_d    = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CW'(WAIT_CYCLES);
                    end
                end
            end
            WAIT: begin
                busy_d = 1'b1;
                // Leaving on the decrement that reaches zero.
                if (cnt_q <= CW'(1)) begin
                    cnt_d   = '0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
                busy_d  = 1'b1;
                ready_d = 1'b1;
                err_d   = err_req_q;
                if (is_read_q) begin
                    rdata_d = err_req_q ? ERR_DATA : mem[widx_q];
                end else begin
                    // The array update lands on the edge that ends the
                    // mem_ready cycle, so a reset during that cycle drops it.
                    wr_pend_d = !err_req_q;
                end
`ifdef MEM_ACCESS_CNT_EN
                if (!err_req_q) begin
                    if (is_read_q) rd_cnt_d = rd_cnt_q + 32'd1;
                    else           wr_cnt_d = wr_cnt_q + 32'd1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            widx_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            is_read_q <= 1'b0;
            err_req_q <= 1'b0;
            wr_pend_q <= 1'b0;
            rdata_q   <= '0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
`ifdef MEM_ACCESS_CNT_EN
            rd_cnt_q  <= '0;
            wr_cnt_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            widx_q    <= widx_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
            is_read_q <= is_read_d;
            err_req_q <= err_req_d;
            wr_pend_q <= wr_pend_d;
            rdata_q   <= rdata_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
`ifdef MEM_ACCESS_CNT_EN
            rd_cnt_q  <= rd_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
`endif
        end
    end

    // The array has no reset; only enabled byte lanes are written.
    always_ff @(posedge clk) begin
        if (wr_pend_q) begin
            for (int b = 0; b < 4; b++) begin
                if (be_q[b]) mem[widx_q][8*b +: 8] <= wdata_q[8*b +: 8];
            end
        end
    end

    assign rdata     = rdata_q;
    assign mem_ready = ready_q;
    assign busy      = busy_q;
    assign err       = err_q;
`ifdef MEM_ACCESS_CNT_EN
    assign rd_count  = rd_cnt_q;
    assign wr_count  = wr_cnt_q;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder
//   Bench for mem_responder. The main instance (WAIT_CYCLES=2) is checked
//   every cycle against a request-level model: each request is recorded with
//   the edge it was accepted on, and busy/mem_ready/err/rdata are derived from
//   that edge, the legality rules and a model memory. A second instance with
//   WAIT_CYCLES=0 is checked against literal timing. Directed literal checks
//   pin the model to hand-computed values.

module tb_mem_responder;

    localparam int unsigned TB_DEPTH = 1024;
    localparam int unsigned TB_WAIT  = 2;
    localparam logic [31:0] TB_ERR   = 32'hDEAD_BEEF;

    logic        clk;
    logic        rst;
    logic        mem_read, mem_write;
    logic [31:0] addr, wdata;
    logic [3:0]  byte_en;
    logic [31:0] rdata;
    logic        mem_ready, busy, err;

    logic        rd0, wr0;
    logic [31:0] addr0, wdata0;
    logic [3:0]  be0;
    logic [31:0] rdata0;
    logic        mem_ready0, busy0, err0;

`ifdef MEM_ACCESS_CNT_EN
    logic [31:0] rd_count, wr_count, rd_count0, wr_count0;
`endif

    mem_responder #(.DEPTH(TB_DEPTH), .WAIT_CYCLES(TB_WAIT), .ERR_DATA(TB_ERR)) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .addr      (addr),
        .wdata     (wdata),
        .byte_en   (byte_en),
        .rdata     (rdata),
        .mem_ready (mem_ready),
        .busy      (busy),
        .err       (err)
`ifdef MEM_ACCESS_CNT_EN
        ,
        .rd_count  (rd_count),
        .wr_count  (wr_count)
`endif
    );

    mem_responder #(.DEPTH(TB_DEPTH), .WAIT_CYCLES(0), .ERR_DATA(TB_ERR)) dut0 (
        .clk       (clk),
        .rst       (rst),
        .mem_read  (rd0),
        .mem_write (wr0),
        .addr      (addr0),
        .wdata     (wdata0),
        .byte_en   (be0),
        .rdata     (rdata0),
        .mem_ready (mem_ready0),
        .busy      (busy0),
        .err       (err0)
`ifdef MEM_ACCESS_CNT_EN
        ,
        .rd_count  (rd_count0),
        .wr_count  (wr_count0)
`endif
    );

    typedef struct {
        int          k;
        logic        rd;
        logic        wr;
        logic [31:0] a;
        logic [31:0] wd;
        logic [3:0]  be;
    } req_t;

    req_t        pend[$];
    logic [31:0] model_mem [int];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_rdata;
    logic        last_err;
    int          last_lat;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Edge counter: after the posedge numbered n, cyc reads n.
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%h required=%h", name, actual, expected);
        end
    endtask

    function automatic logic model_err(input logic rd, input logic wr, input logic [31:0] a);
        return (a[1:0] != 2'b00) || ((a >> 2) >= TB_DEPTH) || (rd && wr);
    endfunction

    // Issue one request on the main instance and wait for its completion.
    // Called at a falling edge; returns at the falling edge inside the
    // mem_ready cycle with the strobes already dropped.
    task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] a,
                                 input logic [31:0] wd, input logic [3:0] be);
        req_t r;
        bit   seen;
        mem_read  = rd;
        mem_write = wr;
        addr      = a;
        wdata     = wd;
        byte_en   = be;
        r.k = cyc + 1;
        r.rd = rd; r.wr = wr; r.a = a; r.wd = wd; r.be = be;
        pend.push_back(r);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (mem_ready) begin
                seen       = 1'b1;
                last_rdata = rdata;
                last_err   = err;
                last_lat   = cyc - r.k;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("[TB] FAIL ready_timeout: actual=no mem_ready required=mem_ready within 20 cycles");
        end
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    // Per-cycle comparison of the main instance against the request model.
    initial begin : compare
        logic [31:0] exp_rdata;
        logic        exp_ready, exp_busy, exp_err;
        int          n, done, idx;
        logic [31:0] w;
`ifdef MEM_ACCESS_CNT_EN
        logic [31:0] exp_rd_cnt, exp_wr_cnt;
        exp_rd_cnt = 0;
        exp_wr_cnt = 0;
`endif
        exp_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                pend.delete();
                exp_rdata = 32'h0;
`ifdef MEM_ACCESS_CNT_EN
                exp_rd_cnt = 0;
                exp_wr_cnt = 0;
`endif
                exp_ready = 1'b0;
                exp_busy  = 1'b0;
                exp_err   = 1'b0;
            end else begin
                n = cyc;
                exp_ready = 1'b0;
                exp_busy  = 1'b0;
                exp_err   = 1'b0;
                if (pend.size() > 0) begin
                    done = pend[0].k + 1 + int'(TB_WAIT);
                    if (n >= pend[0].k && n <= done) exp_busy = 1'b1;
                    if (n == done) begin
                        exp_ready = 1'b1;
                        exp_err   = model_err(pend[0].rd, pend[0].wr, pend[0].a);
                        idx       = int'(pend[0].a >> 2);
                        if (pend[0].rd) begin
                            exp_rdata = exp_err ? TB_ERR
                                      : (model_mem.exists(idx) ? model_mem[idx] : 32'h0);
                        end else if (!exp_err) begin
                            w = model_mem.exists(idx) ? model_mem[idx] : 32'h0;
                            for (int b = 0; b < 4; b++)
                                if (pend[0].be[b]) w[8*b +: 8] = pend[0].wd[8*b +: 8];
                            model_mem[idx] = w;
                        end
`ifdef MEM_ACCESS_CNT_EN
                        if (!exp_err) begin
                            if (pend[0].rd) exp_rd_cnt = exp_rd_cnt + 1;
                            else            exp_wr_cnt = exp_wr_cnt + 1;
                        end
`endif
                    end
                    if (n >= done) void'(pend.pop_front());
                end
            end
            checkOutput("cyc_mem_ready", {31'b0, mem_ready}, {31'b0, exp_ready});
            checkOutput("cyc_busy",      {31'b0, busy},      {31'b0, exp_busy});
            checkOutput("cyc_err",       {31'b0, err},       {31'b0, exp_err});
            checkOutput("cyc_rdata",     rdata,              exp_rdata);
`ifdef MEM_ACCESS_CNT_EN
            checkOutput("cyc_rd_count",  rd_count,           exp_rd_cnt);
            checkOutput("cyc_wr_count",  wr_count,           exp_wr_cnt);
`endif
        end
    end

    initial begin : stimulus
        bit seen;
        rst = 1'b0;
        mem_read = 1'b0; mem_write = 1'b0; addr = '0; wdata = '0; byte_en = '0;
        rd0 = 1'b0; wr0 = 1'b0; addr0 = '0; wdata0 = '0; be0 = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset_rdata",     rdata,              32'h0);
        checkOutput("reset_mem_ready", {31'b0, mem_ready}, 32'h0);
        checkOutput("reset_busy",      {31'b0, busy},      32'h0);
        checkOutput("reset_err",       {31'b0, err},       32'h0);
        rst = 1'b1;
        @(negedge clk);

        $display("[TB] full and partial writes, read-back, latency");
        applyStimulus(1'b0, 1'b1, 32'h0,  32'hCAFE_F00D, 4'hF);
        applyStimulus(1'b0, 1'b1, 32'h10, 32'h1234_5678, 4'hF);
        checkOutput("wr_latency", last_lat, 32'd3);
        checkOutput("wr_err",     {31'b0, last_err}, 32'h0);
        applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
        checkOutput("rd_latency", last_lat, 32'd3);
        checkOutput("rd_data",    last_rdata, 32'h1234_5678);
        checkOutput("rd_err",     {31'b0, last_err}, 32'h0);
        applyStimulus(1'b0, 1'b1, 32'h10, 32'hAABB_CCDD, 4'b0010);
        applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, 4'hF);
        checkOutput("partial_wr_data", last_rdata, 32'h1234_CC78);
        applyStimulus(1'b0, 1'b1, 32'h10, 32'hFFFF_FFFF, 4'b0000);
        checkOutput("be0_wr_err", {31'b0, last_err}, 32'h0);
        applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
        checkOutput("be0_wr_data", last_rdata, 32'h1234_CC78);
        applyStimulus(1'b0, 1'b1, 32'hFFC, 32'h0123_4567, 4'hF);
        applyStimulus(1'b1, 1'b0, 32'hFFC, 32'h0, 4'h0);
        checkOutput("last_word_data", last_rdata, 32'h0123_4567);

        $display("[TB] illegal requests");
        applyStimulus(1'b1, 1'b0, 32'h11, 32'h0, 4'h0);
        checkOutput("misaligned_err",   {31'b0, last_err}, 32'h1);
        checkOutput("misaligned_rdata", last_rdata, 32'hDEAD_BEEF);
        applyStimulus(1'b0, 1'b1, TB_DEPTH * 4, 32'h5555_5555, 4'hF);
        checkOutput("range_wr_err", {31'b0, last_err}, 32'h1);
        applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
        checkOutput("word0_unchanged", last_rdata, 32'hCAFE_F00D);
        applyStimulus(1'b1, 1'b1, 32'h10, 32'h7777_7777, 4'hF);
        checkOutput("both_strobes_err", {31'b0, last_err}, 32'h1);
        applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
        checkOutput("both_strobes_no_write", last_rdata, 32'h1234_CC78);

        $display("[TB] reset during a pending write");
        applyStimulus(1'b0, 1'b1, 32'h20, 32'h0BAD_F00D, 4'hF);
        @(negedge clk);
        begin
            req_t r;
            mem_write = 1'b1; addr = 32'h20; wdata = 32'hFFFF_FFFF; byte_en = 4'hF;
            r.k = cyc + 1; r.rd = 1'b0; r.wr = 1'b1; r.a = 32'h20; r.wd = 32'hFFFF_FFFF; r.be = 4'hF;
            pend.push_back(r);
        end
        @(negedge clk);
        @(negedge clk);
        checkOutput("pre_reset_busy", {31'b0, busy}, 32'h1);
        rst = 1'b0;
        #1;
        checkOutput("midrst_busy",      {31'b0, busy},      32'h0);
        checkOutput("midrst_mem_ready", {31'b0, mem_ready}, 32'h0);
        checkOutput("midrst_err",       {31'b0, err},       32'h0);
        checkOutput("midrst_rdata",     rdata,              32'h0);
        mem_write = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
        checkOutput("post_reset_data", last_rdata, 32'h0BAD_F00D);

        $display("[TB] zero wait-state instance");
        @(negedge clk);
        wr0 = 1'b1; addr0 = 32'h8; wdata0 = 32'h55AA_55AA; be0 = 4'hF;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (mem_ready0) seen = 1'b1;
        end
        checkOutput("w0_write_done", {31'b0, seen}, 32'h1);
        wr0 = 1'b0;
        @(negedge clk);
        rd0 = 1'b1; addr0 = 32'h8;
        @(negedge clk);
        checkOutput("w0_e0_ready", {31'b0, mem_ready0}, 32'h0);
        checkOutput("w0_e0_busy",  {31'b0, busy0},      32'h1);
        @(negedge clk);
        checkOutput("w0_e1_ready", {31'b0, mem_ready0}, 32'h1);
        checkOutput("w0_e1_busy",  {31'b0, busy0},      32'h1);
        checkOutput("w0_e1_rdata", rdata0,              32'h55AA_55AA);
        checkOutput("w0_e1_err",   {31'b0, err0},       32'h0);
        rd0 = 1'b0;
        @(negedge clk);
        checkOutput("w0_e2_ready", {31'b0, mem_ready0}, 32'h0);
        checkOutput("w0_e2_busy",  {31'b0, busy0},      32'h0);
`ifdef MEM_ACCESS_CNT_EN
        checkOutput("w0_rd_count", rd_count0, 32'd1);
        checkOutput("w0_wr_count", wr_count0, 32'd1);

        $display("[TB] access counters");
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        applyStimulus(1'b0, 1'b1, 32'h30, 32'h1111_1111, 4'hF);
        applyStimulus(1'b0, 1'b1, 32'h34, 32'h2222_2222, 4'hF);
        applyStimulus(1'b1, 1'b0, 32'h30, 32'h0, 4'h0);
        applyStimulus(1'b1, 1'b0, 32'h34, 32'h0, 4'h0);
        applyStimulus(1'b1, 1'b0, 32'h0,  32'h0, 4'h0);
        applyStimulus(1'b1, 1'b0, 32'h3,  32'h0, 4'h0);
        checkOutput("cnt_rd", rd_count, 32'd3);
        checkOutput("cnt_wr", wr_count, 32'd2);
`endif

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
